// File: rtl/axisoc_uart_pkg.sv
// Shared UART types and constants for the axisoc serial blocks.
// Holds the receiver FSM state encoding and the baud divisor helper.
package axisoc_uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    // Rounded clock cycles per bit for a given clock and baud rate.
    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/axisoc_uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// RESET_VAL sets the value both flops take while in reset.
module axisoc_uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/axisoc_uart_rx.sv
// 8N1 UART receiver with a one-entry valid/ready output buffer.
// Define AXISOC_UART_RX_PARITY_EN to add an even-parity bit after bit 7.
module axisoc_uart_rx
    import axisoc_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iRX,
    input  logic       iReady,
    output logic [7:0] oData,
    output logic       oValid,
    output logic       oFrameError,
    output logic       oOverrun,
    output logic       oBusy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] I_LAST = IW'(UART_DATA_BITS - 1);

    logic                      w_rxs;
    logic                      w_par_ok;
    uart_state_e               r_state;
    logic [CW-1:0]             r_cnt;
    logic [IW-1:0]             r_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_good;
    logic                      r_bad;

    axisoc_uart_sync2 #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .i_clk(Clock),
        .i_rst(Reset),
        .i_d  (iRX),
        .o_q  (w_rxs)
    );

`ifdef AXISOC_UART_RX_PARITY_EN
    logic r_par;
    assign w_par_ok = ~(r_par ^ (^r_shift));
`else
    assign w_par_ok = 1'b1;
`endif

    // r_good/r_bad strobe the buffer one cycle after the stop sample.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_good  <= 1'b0;
            r_bad   <= 1'b0;
`ifdef AXISOC_UART_RX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_good <= 1'b0;
            r_bad  <= 1'b0;
            r_cnt  <= r_cnt + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (!w_rxs) r_state <= ST_START;
                end
                ST_START: begin
                    if (r_cnt == C_HALF) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_state <= w_rxs ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rxs, r_shift[UART_DATA_BITS-1:1]};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == I_LAST) begin
`ifdef AXISOC_UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef AXISOC_UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt   <= '0;
                        r_par   <= w_rxs;
                        r_state <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    if (r_cnt == C_LAST) begin
                        r_cnt <= '0;
                        if (w_rxs && w_par_ok) begin
                            r_good  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_bad   <= 1'b1;
                            r_state <= ST_BREAK;
                        end
                    end
                end
                ST_BREAK: begin
                    r_cnt <= '0;
                    if (w_rxs) r_state <= ST_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            oData       <= '0;
            oValid      <= 1'b0;
            oFrameError <= 1'b0;
            oOverrun    <= 1'b0;
        end else begin
            oFrameError <= r_bad;
            oOverrun    <= 1'b0;
            if (r_good) begin
                if (!oValid || iReady) begin
                    oData  <= r_shift;
                    oValid <= 1'b1;
                end else begin
                    oOverrun <= 1'b1;
                end
            end else if (oValid && iReady) begin
                oValid <= 1'b0;
            end
        end
    end

    assign oBusy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_axisoc_uart_rx.sv
// Directed bench for axisoc_uart_rx at CLKS_PER_BIT=8.
// Frames are driven on iRX; a negedge monitor tallies output events.
module tb_axisoc_uart_rx;

    localparam int CPB = 8;
    localparam int H   = CPB / 2;

    logic       clk = 1'b0;
    logic       Reset;
    logic       iRX;
    logic       iReady;
    logic [7:0] oData;
    logic       oValid;
    logic       oFrameError;
    logic       oOverrun;
    logic       oBusy;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    int         v_rise, v_cyc, v_hi, fe_cnt, fe_cyc, ov_cnt, ov_cyc, busy_cnt;
    logic [7:0] v_data;
    logic       pv = 1'b0;

    axisoc_uart_rx #(
        .CLKS_PER_BIT(CPB)
    ) dut (
        .Clock      (clk),
        .Reset      (Reset),
        .iRX        (iRX),
        .iReady     (iReady),
        .oData      (oData),
        .oValid     (oValid),
        .oFrameError(oFrameError),
        .oOverrun   (oOverrun),
        .oBusy      (oBusy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (oValid === 1'b1 && pv !== 1'b1) begin
            v_rise = v_rise + 1;
            v_cyc  = cyc;
            v_data = oData;
        end
        pv = oValid;
        if (oValid === 1'b1) v_hi = v_hi + 1;
        if (oFrameError === 1'b1) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
        if (oOverrun === 1'b1) begin
            ov_cnt = ov_cnt + 1;
            ov_cyc = cyc;
        end
        if (oBusy === 1'b1) busy_cnt = busy_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        v_rise = 0; v_cyc = 0; v_hi = 0; v_data = 8'h00;
        fe_cnt = 0; fe_cyc = 0; ov_cnt = 0; ov_cyc = 0; busy_cnt = 0;
    endtask

    // Call at or just after a posedge; returns at the posedge ending the stop bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, output int t0);
        #1;
        iRX = 1'b0;
        t0  = cyc + 1;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            iRX = b[i];
            repeat (CPB) @(posedge clk);
        end
        #1;
        iRX = stop;
        repeat (CPB) @(posedge clk);
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        iRX    = 1'b1;
        iReady = 1'b0;
        clear_counts();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (oData !== 8'h00) begin fails++; $display("FAIL reset_data got %h want 00", oData); end
        checks++; if (oValid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", oValid); end
        checks++; if (oFrameError !== 1'b0) begin fails++; $display("FAIL reset_fe got %b want 0", oFrameError); end
        checks++; if (oOverrun !== 1'b0) begin fails++; $display("FAIL reset_ov got %b want 0", oOverrun); end
        checks++; if (oBusy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", oBusy); end
        Reset = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic test_basic();
        int t0;
        iReady = 1'b1;
        clear_counts();
        @(posedge clk);
        send_frame(8'hA5, 1'b1, t0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (v_rise !== 1) begin fails++; $display("FAIL basic_rise got %0d want 1", v_rise); end
        checks++; if (v_cyc !== t0 + 79) begin fails++; $display("FAIL basic_latency got %0d want %0d", v_cyc - t0, 79); end
        checks++; if (v_data !== 8'hA5) begin fails++; $display("FAIL basic_data got %h want a5", v_data); end
        checks++; if (v_hi !== 1) begin fails++; $display("FAIL basic_pulse_width got %0d want 1", v_hi); end
        checks++; if (fe_cnt + ov_cnt !== 0) begin fails++; $display("FAIL basic_err got %0d want 0", fe_cnt + ov_cnt); end
        checks++; if (oBusy !== 1'b0) begin fails++; $display("FAIL basic_busy got %b want 0", oBusy); end
    endtask

    task automatic test_glitch();
        clear_counts();
        @(posedge clk);
        #1 iRX = 1'b0;
        @(posedge clk);
        #1 iRX = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checks++; if (busy_cnt < H || busy_cnt > H + 1) begin fails++; $display("FAIL glitch_busy_len got %0d want %0d..%0d", busy_cnt, H, H + 1); end
        checks++; if (v_rise !== 0) begin fails++; $display("FAIL glitch_valid got %0d want 0", v_rise); end
        checks++; if (fe_cnt !== 0) begin fails++; $display("FAIL glitch_fe got %0d want 0", fe_cnt); end
        checks++; if (oBusy !== 1'b0) begin fails++; $display("FAIL glitch_idle got %b want 0", oBusy); end
    endtask

    task automatic test_frame_error();
        int t0;
        clear_counts();
        @(posedge clk);
        send_frame(8'h3C, 1'b0, t0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        checks++; if (fe_cnt !== 1) begin fails++; $display("FAIL fe_count got %0d want 1", fe_cnt); end
        checks++; if (fe_cyc !== t0 + 79) begin fails++; $display("FAIL fe_timing got %0d want %0d", fe_cyc - t0, 79); end
        checks++; if (oBusy !== 1'b1) begin fails++; $display("FAIL fe_break_busy got %b want 1", oBusy); end
        @(posedge clk);
        #1 iRX = 1'b1;
        repeat (100) @(posedge clk);
        @(negedge clk);
        checks++; if (v_rise !== 0) begin fails++; $display("FAIL fe_no_valid got %0d want 0", v_rise); end
        checks++; if (fe_cnt !== 1) begin fails++; $display("FAIL fe_no_retrigger got %0d want 1", fe_cnt); end
        checks++; if (oBusy !== 1'b0) begin fails++; $display("FAIL fe_idle got %b want 0", oBusy); end
    endtask

    task automatic test_back_to_back_overrun();
        int t0;
        int t1;
        iReady = 1'b0;
        clear_counts();
        @(posedge clk);
        send_frame(8'h11, 1'b1, t0);
        send_frame(8'h22, 1'b1, t1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (t1 !== t0 + 80) begin fails++; $display("FAIL b2b_gap got %0d want 80", t1 - t0); end
        checks++; if (oValid !== 1'b1) begin fails++; $display("FAIL ovr_valid got %b want 1", oValid); end
        checks++; if (oData !== 8'h11) begin fails++; $display("FAIL ovr_data got %h want 11", oData); end
        checks++; if (ov_cnt !== 1) begin fails++; $display("FAIL ovr_count got %0d want 1", ov_cnt); end
        checks++; if (ov_cyc !== t1 + 79) begin fails++; $display("FAIL ovr_timing got %0d want 79", ov_cyc - t1); end
        @(posedge clk);
        #1 iReady = 1'b1;
        @(posedge clk);
        #1 iReady = 1'b0;
        @(negedge clk);
        checks++; if (oValid !== 1'b0) begin fails++; $display("FAIL ovr_consume got %b want 0", oValid); end
        checks++; if (oData !== 8'h11) begin fails++; $display("FAIL ovr_data_hold got %h want 11", oData); end
    endtask

    task automatic test_ready_on_delivery();
        int t0;
        int t1;
        iReady = 1'b0;
        clear_counts();
        @(posedge clk);
        send_frame(8'h11, 1'b1, t0);
        fork
            send_frame(8'h22, 1'b1, t1);
            begin
                #1;
                repeat (79) @(posedge clk);
                #1 iReady = 1'b1;
                @(posedge clk);
                #1 iReady = 1'b0;
            end
        join
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (oData !== 8'h22) begin fails++; $display("FAIL rod_data got %h want 22", oData); end
        checks++; if (oValid !== 1'b1) begin fails++; $display("FAIL rod_valid got %b want 1", oValid); end
        checks++; if (ov_cnt !== 0) begin fails++; $display("FAIL rod_overrun got %0d want 0", ov_cnt); end
        checks++; if (v_rise !== 1) begin fails++; $display("FAIL rod_single_rise got %0d want 1", v_rise); end
    endtask

    task automatic test_reset_mid_frame();
        int t0;
        clear_counts();
        @(posedge clk);
        #1 iRX = 1'b0;
        repeat (CPB) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 iRX = 1'b0;
            repeat (CPB) @(posedge clk);
        end
        #1 iRX = 1'b1;
        repeat (4) @(posedge clk);
        checks++; if (oBusy !== 1'b1) begin fails++; $display("FAIL rst_mid_busy_before got %b want 1", oBusy); end
        #1 Reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (oValid !== 1'b0) begin fails++; $display("FAIL rst_mid_valid got %b want 0", oValid); end
        checks++; if (oData !== 8'h00) begin fails++; $display("FAIL rst_mid_data got %h want 00", oData); end
        checks++; if (oBusy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", oBusy); end
        checks++; if (oFrameError !== 1'b0 || oOverrun !== 1'b0) begin fails++; $display("FAIL rst_mid_pulses got %b%b want 00", oFrameError, oOverrun); end
        Reset = 1'b0;
        repeat (10) @(posedge clk);
        checks++; if (fe_cnt + ov_cnt !== 0) begin fails++; $display("FAIL rst_mid_no_pulse got %0d want 0", fe_cnt + ov_cnt); end
        clear_counts();
        iReady = 1'b1;
        send_frame(8'h5A, 1'b1, t0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++; if (v_data !== 8'h5A) begin fails++; $display("FAIL rst_after_data got %h want 5a", v_data); end
        checks++; if (v_cyc !== t0 + 79) begin fails++; $display("FAIL rst_after_latency got %0d want 79", v_cyc - t0); end
        checks++; if (v_rise !== 1) begin fails++; $display("FAIL rst_after_rise got %0d want 1", v_rise); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_error();
        test_back_to_back_overrun();
        test_ready_on_delivery();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/axisoc_uart_rx.md
# axisoc_uart_rx

Serial UART receiver that decodes 8N1 frames arriving on a single line (e.g. the SoC `oTX` pin looped back, or an external host) into bytes presented on a valid/ready interface. It is the receiving end of the SoC transmit path. It sits in the `clk50` domain beside the SoC top level and feeds the bench-side or host-side byte consumer. It oversamples by clock count rather than by a separate baud tick.

## Interface
- `CLKS_PER_BIT`, default 434, Clock cycles per bit (50 MHz / 115200); must be ≥ 4.
- `Clock`  in  1  single clock, rising edge.
- `Reset`  in  1  synchronous, active-high.
- `iRX`  in  1  asynchronous serial line; idle high.
- `iReady`  in  1  consumer accepts `oData` when `oValid && iReady`.
- `oData`  out  8  received byte, LSB first on the wire.
- `oValid`  out  1  `oData` holds an unconsumed byte.
- `oFrameError`  out  1  one-cycle pulse: stop bit (or parity, if enabled) sampled bad.
- `oOverrun`  out  1  one-cycle pulse: good byte dropped because the buffer was full.
- `oBusy`  out  1  high while the FSM is not in IDLE.

## Operation
- `iRX` passes through a 2-flop synchronizer, reset to 1. All decisions use the synchronized value `rxs`.
- Let H = CLKS_PER_BIT/2 (floor). A bit counter counts 0..CLKS_PER_BIT-1, and a bit index counts 0..7.
- FSM states:
  - IDLE: when `rxs`==0, clear the counter and go to START.
  - START: at count H-1, sample. If `rxs`==1 (glitch), go to IDLE with no output. Otherwise clear the counter and go to DATA.
  - DATA: at count CLKS_PER_BIT-1, shift `rxs` into the shift register MSB (right shift). After index 7, go to PARITY if enabled, else STOP.
  - PARITY: at count CLKS_PER_BIT-1, sample, then go to STOP.
  - STOP: at count CLKS_PER_BIT-1, sample.
    - If 1 and parity OK, deliver the byte and go to IDLE.
    - Otherwise pulse `oFrameError`, discard the byte, and go to BREAK.
  - BREAK: wait for `rxs`==1, then go to IDLE. This prevents a held-low line from re-triggering a start.
- Output buffer, one entry:
  - Delivery when `oValid`==0: load `oData` and set `oValid`.
  - Delivery when `oValid`==1 and `iReady`==1 in the same cycle: load the new byte; `oValid` stays 1.
  - Delivery when `oValid`==1 and `iReady`==0: keep the old byte and pulse `oOverrun`.
  - Consumption with no delivery: clear `oValid`. `oData` holds its last value.
- Reset mid-frame aborts the frame. The FSM goes to IDLE, the buffer is cleared, and no pulses are emitted.

## Timing
- Reset values: `oData`=0, `oValid`=0, `oFrameError`=0, `oOverrun`=0, `oBusy`=0. Synchronizer flops = 1.
- Start edge: let T0 be the first edge at which `iRX`==0 is registered. `rxs` goes low at T0+1, and START is entered at T0+2.
- Data bit k is sampled at T0+2+H+(k+1)·CLKS_PER_BIT. Parity/stop is sampled one bit period later.
- `oValid` rises 1 cycle after the stop sample: T0+3+H+9·CLKS_PER_BIT. Add CLKS_PER_BIT with parity.
- `oFrameError` and `oOverrun` are high for exactly the cycle in which `oValid` would have been updated.
- `oBusy` is high from START entry until the cycle after the final sample (or the BREAK exit).
- Back-to-back frames: a start bit beginning immediately after the stop-bit midpoint is detected. No idle gap is required.

## Configuration
- `AXISOC_UART_RX_PARITY_EN` defined: an even-parity bit follows bit 7. The PARITY state is compiled in, and a mismatch is treated like a bad stop bit.
- Not defined: pure 8N1. The PARITY state and its logic are absent.

## Structure
- Package `axisoc_uart_pkg` holds:
  - the FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - `UART_DATA_BITS`=8;
  - a function computing CLKS_PER_BIT from clock Hz and baud.
- Sub-module `axisoc_uart_sync2`: 2-flop synchronizer with a reset value parameter. It is reused by the transmitter-side `iRX`.

## Test plan
All scenarios use CLKS_PER_BIT=8.
- Reset, then send 0xA5 8N1 with `iReady`=1 → `oValid` pulses 1 cycle with `oData`=0xA5, at T0+3+4+72 = T0+79; no error pulses.
- 1-cycle low glitch on idle line → no `oValid`; `oBusy` high for ~H+1 cycles, then IDLE.
- 0x3C with stop bit driven 0, line held low 40 cycles → one `oFrameError` pulse; no `oValid`; no new start until the line returns high.
- `iReady`=0; send 0x11 then 0x22 → `oData`=0x11 kept, one `oOverrun` pulse; assert `iReady` → `oValid` drops.
- `oValid`=1 with 0x11; assert `iReady` exactly on the 0x22 delivery cycle → `oData`=0x22, `oValid` stays 1, no overrun.
- Assert `Reset` during data bit 3 → all outputs 0 next cycle; a following 0x5A frame is received correctly.
